// File: rtl/lfsr_3bit.sv
// 3-bit maximal-length XNOR LFSR (period 7) feeding the pipe-pattern generator.
// Q[0] is the newest bit; the 3'b111 lock-up state is escaped to 3'b000.
module lfsr_3bit #(
    parameter logic [2:0] SEED = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] Q
);

    logic       fb;
    logic [2:0] next_q;

    // XNOR feedback alone would hold 111 forever, so that state is forced back into the sequence.
    always_comb begin
        fb     = ~(Q[2] ^ Q[1]);
        next_q = {Q[1], Q[0], fb};
        if (Q == 3'b111) begin
            next_q = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q <= SEED;
        end else begin
            Q <= next_q;
        end
    end

endmodule

// File: tb/tb_lfsr_3bit.sv
// Self-checking bench for lfsr_3bit: directed steps plus random resets, checked against
// a table-driven model of the published state sequence for three SEED values.
module tb_lfsr_3bit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] q_a, q_b, q_c;

    int errors = 0;
    int checks = 0;

    // Published sequence starting from 000; the model walks an index through it.
    logic [2:0] seq [7] = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100};
    logic [2:0] exp14 [14] = '{3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100, 3'b000,
                               3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100, 3'b000};
    logic       stream [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] exp_b [7] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b011, 3'b110, 3'b101};

    int ia = 0;
    int ib = 0;
    int ic = 0;
    bit c_locked = 1'b0;

    always #5 clk = ~clk;

    lfsr_3bit #(.SEED(3'b000)) dut_a (.clk(clk), .reset(reset), .Q(q_a));
    lfsr_3bit #(.SEED(3'b101)) dut_b (.clk(clk), .reset(reset), .Q(q_b));
    lfsr_3bit #(.SEED(3'b111)) dut_c (.clk(clk), .reset(reset), .Q(q_c));

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive reset away from the edge, sample 1ns after it, advance the model and compare.
    task automatic tick(input logic r);
        @(negedge clk);
        reset = r;
        @(posedge clk);
        #1;
        if (r) begin
            ia = 0;
            ib = 4;
            c_locked = 1'b1;
        end else begin
            ia = (ia + 1) % 7;
            ib = (ib + 1) % 7;
            if (c_locked) begin
                c_locked = 1'b0;
                ic = 0;
            end else begin
                ic = (ic + 1) % 7;
            end
        end
        check("model_seed000", q_a, seq[ia]);
        check("model_seed101", q_b, seq[ib]);
        check("model_seed111", q_c, c_locked ? 3'b111 : seq[ic]);
    endtask

    initial begin
        // Reset and reset hold
        tick(1'b1);
        check("reset_value", q_a, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            check("reset_hold", q_a, 3'b000);
        end

        // Two full periods
        for (int i = 0; i < 14; i++) begin
            tick(1'b0);
            check("full_sequence", q_a, exp14[i]);
        end

        // Q[0] decision-bit stream from the reset value
        tick(1'b1);
        check("q0_stream", {2'b00, q_a[0]}, {2'b00, stream[0]});
        for (int i = 1; i < 7; i++) begin
            tick(1'b0);
            check("q0_stream", {2'b00, q_a[0]}, {2'b00, stream[i]});
        end

        // Mid-run reset restarts from SEED
        tick(1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("midrun_before", q_a, 3'b110);
        tick(1'b1);
        check("midrun_reset", q_a, 3'b000);
        tick(1'b0);
        check("midrun_resume", q_a, 3'b001);

        // Lock-up recovery via the SEED=111 instance, and SEED=101 sequence
        tick(1'b1);
        check("lockup_loaded", q_c, 3'b111);
        check("seed101_reset", q_b, 3'b101);
        tick(1'b0);
        check("lockup_escape", q_c, 3'b000);
        check("seed101_seq", q_b, exp_b[0]);
        tick(1'b0);
        check("lockup_resume", q_c, 3'b001);
        check("seed101_seq", q_b, exp_b[1]);
        tick(1'b0);
        check("lockup_resume", q_c, 3'b011);
        check("seed101_seq", q_b, exp_b[2]);
        for (int i = 3; i < 7; i++) begin
            tick(1'b0);
            check("seed101_seq", q_b, exp_b[i]);
        end

        // Random reset pattern against the model
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 5) == 0);
            checks++;
            assert (q_a !== 3'b111) else begin
                errors++;
                $error("FAIL never_111 observed=%b expected=not 111", q_a);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
